can_mc_if: RTL and testbench

CAN_MC_IF -- requirements
Module: can_mc_if

---
 rtl/can_mc_if_pkg.sv | 25 ++
 rtl/can_mc_if_addr_dec.sv | 25 ++
 rtl/can_mc_if.sv | 175 +++++++++++++++++
 tb/tb_can_mc_if.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/can_mc_if_pkg.sv
// -----------------------------------------------------------------------------
// can_mc_if_pkg
// Shared types and constants for the CAN microcontroller register interface.
//   state_t     : transaction FSM states
//   ADDR_LIMIT  : first byte address outside the register map
//   TIMEOUT_LEN : READ_WAIT cycles before giving up (used only when
//                 CAN_MC_IF_TIMEOUT_EN is defined)
//   RS_W        : width of the one-hot register-select vector
// -----------------------------------------------------------------------------
package can_mc_if_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ_WAIT,
      WRITE,
      DONE,
      ERR
   } state_t;

   localparam logic [5:0] ADDR_LIMIT  = 6'h30;
   localparam int         TIMEOUT_LEN = 16;
   localparam int         TIMEOUT_W   = $clog2(TIMEOUT_LEN);
   localparam int         RS_W        = 31;

endpackage

// File: rtl/can_mc_if_addr_dec.sv
// -----------------------------------------------------------------------------
// can_mc_if_addr_dec
// Combinational register-address decoder.
//   i_addr    : register byte address (word aligned, registers are 16-bit apart)
//   o_valid   : address is even and below ADDR_LIMIT
//   o_one_hot : one-hot select, bit = i_addr[5:1]; all zero when invalid
// -----------------------------------------------------------------------------
module can_mc_if_addr_dec
   import can_mc_if_pkg::*;
(
   input  logic [5:0]      i_addr,
   output logic            o_valid,
   output logic [RS_W-1:0] o_one_hot
);

   always_comb begin
      o_valid   = (i_addr[0] == 1'b0) && (i_addr < ADDR_LIMIT);
      o_one_hot = '0;
      // Valid indices stop at 23, so bits 24..30 can never be reached.
      if (o_valid) begin
         o_one_hot = RS_W'(1) << i_addr[5:1];
      end
   end

endmodule

// File: rtl/can_mc_if.sv
// -----------------------------------------------------------------------------
// can_mc_if
// Bridges a wrapper-side chip-select bus onto the CAN configuration register
// block. Each new request on the wrapper side becomes one register access:
// reads wait for i_reg_ack, writes take a single cycle. Completion is signalled
// by a one-cycle o_ack, decode or register errors by a one-cycle o_error.
//
// Ports
//   i_sys_clk    : system clock, rising edge
//   i_reset      : synchronous, active-high reset
//   i_bus_data   : write data from wrapper
//   i_addr       : register byte address from wrapper
//   i_r_neg_w    : 1 = read, 0 = write
//   i_cs         : chip select
//   o_reg_data   : last completed read data
//   o_ack        : transaction-complete pulse
//   o_error      : error pulse
//   i_reg_r_data : read data from configuration register
//   i_reg_ack    : read-complete strobe from configuration register
//   i_reg_error  : error strobe from configuration register
//   o_reg_w_bus  : last valid write data
//   o_rs_vector  : one-hot register select
//   o_r_neg_w    : direction to configuration register
//
// Build option
//   CAN_MC_IF_TIMEOUT_EN : READ_WAIT aborts to ERR after TIMEOUT_LEN cycles
//                          without i_reg_ack. Undefined: waits indefinitely.
// -----------------------------------------------------------------------------
module can_mc_if
   import can_mc_if_pkg::*;
(
   input  logic            i_sys_clk,
   input  logic            i_reset,
   input  logic [31:0]     i_bus_data,
   input  logic [5:0]      i_addr,
   input  logic            i_r_neg_w,
   input  logic            i_cs,
   output logic [31:0]     o_reg_data,
   output logic            o_ack,
   output logic            o_error,
   input  logic [31:0]     i_reg_r_data,
   input  logic            i_reg_ack,
   input  logic            i_reg_error,
   output logic [31:0]     o_reg_w_bus,
   output logic [RS_W-1:0] o_rs_vector,
   output logic            o_r_neg_w
);

   state_t          state_q, state_n;
   logic            cs_q;
   logic            last_vld_q, last_vld_n;
   logic [6:0]      last_req_q, last_req_n;
   logic [6:0]      req;
   logic            start;
   logic            addr_valid;
   logic [RS_W-1:0] addr_one_hot;
   logic [RS_W-1:0] rs_n;
   logic            rnw_n;
   logic [31:0]     data_n;
   logic [31:0]     wbus_n;
   logic            ack_n;
   logic            err_n;
`ifdef CAN_MC_IF_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_n;
`endif

   can_mc_if_addr_dec u_addr_dec (
      .i_addr    (i_addr),
      .o_valid   (addr_valid),
      .o_one_hot (addr_one_hot)
   );

   // A request that stays asserted and unchanged after completing must not
   // launch a second access; a fresh chip-select edge or a new command does.
   assign req   = {i_r_neg_w, i_addr};
   assign start = i_cs && (!cs_q || !last_vld_q || (req != last_req_q));

   always_comb begin
      state_n    = state_q;
      rs_n       = o_rs_vector;
      rnw_n      = o_r_neg_w;
      data_n     = o_reg_data;
      wbus_n     = o_reg_w_bus;
      last_vld_n = last_vld_q;
      last_req_n = last_req_q;
`ifdef CAN_MC_IF_TIMEOUT_EN
      to_cnt_n   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               last_vld_n = 1'b1;
               last_req_n = req;
               if (!addr_valid) begin
                  state_n = ERR;
               end else if (i_r_neg_w) begin
                  rs_n    = addr_one_hot;
                  rnw_n   = 1'b1;
                  state_n = READ_WAIT;
               end else begin
                  wbus_n  = i_bus_data;
                  rs_n    = addr_one_hot;
                  rnw_n   = 1'b0;
                  state_n = WRITE;
               end
            end
         end
         READ_WAIT: begin
            // Dropping chip select is a silent abort: no ack, no error.
            if (!i_cs) begin
               rs_n    = '0;
               state_n = IDLE;
            end else if (i_reg_error) begin
               rs_n    = '0;
               state_n = ERR;
            end else if (i_reg_ack) begin
               data_n  = i_reg_r_data;
               rs_n    = '0;
               state_n = DONE;
            end
`ifdef CAN_MC_IF_TIMEOUT_EN
            else if (to_cnt_q == TIMEOUT_W'(TIMEOUT_LEN - 1)) begin
               rs_n    = '0;
               state_n = ERR;
            end else begin
               to_cnt_n = to_cnt_q + 1'b1;
            end
`endif
         end
         WRITE: begin
            rs_n    = '0;
            state_n = i_reg_error ? ERR : DONE;
         end
         DONE:    state_n = IDLE;
         ERR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Pulses are registered so they coincide exactly with DONE / ERR.
      ack_n = (state_n == DONE);
      err_n = (state_n == ERR);
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         cs_q        <= 1'b0;
         last_vld_q  <= 1'b0;
         last_req_q  <= '0;
         o_rs_vector <= '0;
         o_r_neg_w   <= 1'b0;
         o_reg_data  <= '0;
         o_reg_w_bus <= '0;
         o_ack       <= 1'b0;
         o_error     <= 1'b0;
`ifdef CAN_MC_IF_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_n;
         cs_q        <= i_cs;
         last_vld_q  <= last_vld_n;
         last_req_q  <= last_req_n;
         o_rs_vector <= rs_n;
         o_r_neg_w   <= rnw_n;
         o_reg_data  <= data_n;
         o_reg_w_bus <= wbus_n;
         o_ack       <= ack_n;
         o_error     <= err_n;
`ifdef CAN_MC_IF_TIMEOUT_EN
         to_cnt_q    <= to_cnt_n;
`endif
      end
   end

endmodule

// File: tb/tb_can_mc_if.sv
// -----------------------------------------------------------------------------
// tb_can_mc_if
// Directed bench for can_mc_if: reset state, valid/invalid reads and writes,
// decode boundaries, chip-select abort, back-to-back with chip select held,
// and reset during a pending read.
// -----------------------------------------------------------------------------
module tb_can_mc_if;
   import can_mc_if_pkg::*;

   logic        i_sys_clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_bus_data;
   logic [5:0]  i_addr;
   logic        i_r_neg_w;
   logic        i_cs;
   logic [31:0] o_reg_data;
   logic        o_ack;
   logic        o_error;
   logic [31:0] i_reg_r_data;
   logic        i_reg_ack;
   logic        i_reg_error;
   logic [31:0] o_reg_w_bus;
   logic [30:0] o_rs_vector;
   logic        o_r_neg_w;

   int n_vec = 0;
   int n_err = 0;
   int ack_cnt = 0;
   int err_cnt = 0;
   int a0, e0;

   can_mc_if dut (
      .i_sys_clk    (i_sys_clk),
      .i_reset      (i_reset),
      .i_bus_data   (i_bus_data),
      .i_addr       (i_addr),
      .i_r_neg_w    (i_r_neg_w),
      .i_cs         (i_cs),
      .o_reg_data   (o_reg_data),
      .o_ack        (o_ack),
      .o_error      (o_error),
      .i_reg_r_data (i_reg_r_data),
      .i_reg_ack    (i_reg_ack),
      .i_reg_error  (i_reg_error),
      .o_reg_w_bus  (o_reg_w_bus),
      .o_rs_vector  (o_rs_vector),
      .o_r_neg_w    (o_r_neg_w)
   );

   always #5 i_sys_clk = ~i_sys_clk;

   // Pulse counters sampled mid-cycle, away from the active edge.
   always @(negedge i_sys_clk) begin
      if (o_ack)   ack_cnt <= ack_cnt + 1;
      if (o_error) err_cnt <= err_cnt + 1;
   end

   task automatic tick();
      @(posedge i_sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      i_reset      = 1'b1;
      i_bus_data   = '0;
      i_addr       = '0;
      i_r_neg_w    = 1'b0;
      i_cs         = 1'b0;
      i_reg_r_data = '0;
      i_reg_ack    = 1'b0;
      i_reg_error  = 1'b0;
      tick();
      tick();
      i_reset = 1'b0;
      chk("rst_reg_data", o_reg_data, 32'h0);
      chk("rst_w_bus",    o_reg_w_bus, 32'h0);
      chk("rst_rs",       32'(o_rs_vector), 32'h0);
      chk("rst_ack",      32'(o_ack), 32'h0);
      chk("rst_err",      32'(o_error), 32'h0);
      chk("rst_rnw",      32'(o_r_neg_w), 32'h0);

      // invalid read of 0x30
      a0 = ack_cnt; e0 = err_cnt;
      i_cs = 1'b1; i_r_neg_w = 1'b1; i_addr = 6'h30;
      tick();
      chk("inv_rd_err",  32'(o_error), 32'h1);
      chk("inv_rd_rs",   32'(o_rs_vector), 32'h0);
      chk("inv_rd_data", o_reg_data, 32'h0);
      i_cs = 1'b0;
      tick();
      chk("inv_rd_err_cnt", 32'(err_cnt - e0), 32'h1);
      chk("inv_rd_ack_cnt", 32'(ack_cnt - a0), 32'h0);

      // valid read of 0x00, ack after three cycles
      a0 = ack_cnt;
      i_cs = 1'b1; i_r_neg_w = 1'b1; i_addr = 6'h00;
      tick();
      chk("rd_rs",  32'(o_rs_vector), 32'h1);
      chk("rd_rnw", 32'(o_r_neg_w), 32'h1);
      tick();
      tick();
      chk("rd_rs_hold", 32'(o_rs_vector), 32'h1);
      i_reg_ack = 1'b1; i_reg_r_data = 32'h10;
      tick();
      chk("rd_data",     o_reg_data, 32'h10);
      chk("rd_ack",      32'(o_ack), 32'h1);
      chk("rd_rs_clear", 32'(o_rs_vector), 32'h0);
      i_reg_ack = 1'b0; i_cs = 1'b0;
      tick();
      chk("rd_ack_low", 32'(o_ack), 32'h0);
      chk("rd_ack_cnt", 32'(ack_cnt - a0), 32'h1);

      // valid write of 0x20 with 0x03
      a0 = ack_cnt;
      i_cs = 1'b1; i_r_neg_w = 1'b0; i_addr = 6'h20; i_bus_data = 32'h3;
      tick();
      chk("wr_w_bus", o_reg_w_bus, 32'h3);
      chk("wr_rs",    32'(o_rs_vector), 32'h0001_0000);
      chk("wr_rnw",   32'(o_r_neg_w), 32'h0);
      tick();
      chk("wr_rs_clear", 32'(o_rs_vector), 32'h0);
      chk("wr_ack",      32'(o_ack), 32'h1);
      i_cs = 1'b0;
      tick();
      chk("wr_ack_cnt", 32'(ack_cnt - a0), 32'h1);

      // invalid write of 0x30 with 0x04
      a0 = ack_cnt; e0 = err_cnt;
      i_cs = 1'b1; i_r_neg_w = 1'b0; i_addr = 6'h30; i_bus_data = 32'h4;
      tick();
      chk("inv_wr_err",   32'(o_error), 32'h1);
      chk("inv_wr_w_bus", o_reg_w_bus, 32'h3);
      chk("inv_wr_rs",    32'(o_rs_vector), 32'h0);
      i_cs = 1'b0;
      tick();
      chk("inv_wr_err_low", 32'(o_error), 32'h0);
      chk("inv_wr_err_cnt", 32'(err_cnt - e0), 32'h1);
      chk("inv_wr_ack_cnt", 32'(ack_cnt - a0), 32'h0);

      // highest valid address 0x2E selects bit 23
      i_cs = 1'b1; i_r_neg_w = 1'b1; i_addr = 6'h2E;
      tick();
      chk("top_rs", 32'(o_rs_vector), 32'h0080_0000);
      i_reg_ack = 1'b1; i_reg_r_data = 32'hCAFE_0001;
      tick();
      chk("top_data", o_reg_data, 32'hCAFE_0001);
      i_reg_ack = 1'b0; i_cs = 1'b0;
      tick();

      // odd address is rejected
      i_cs = 1'b1; i_r_neg_w = 1'b0; i_addr = 6'h01; i_bus_data = 32'h55;
      tick();
      chk("odd_err",   32'(o_error), 32'h1);
      chk("odd_w_bus", o_reg_w_bus, 32'h3);
      i_cs = 1'b0;
      tick();

      // chip select dropped during READ_WAIT aborts silently
      a0 = ack_cnt; e0 = err_cnt;
      i_cs = 1'b1; i_r_neg_w = 1'b1; i_addr = 6'h04;
      tick();
      chk("abort_rs", 32'(o_rs_vector), 32'h4);
      i_cs = 1'b0;
      tick();
      chk("abort_rs_clear", 32'(o_rs_vector), 32'h0);
      tick();
      chk("abort_no_ack",  32'(ack_cnt - a0), 32'h0);
      chk("abort_no_err",  32'(err_cnt - e0), 32'h0);
      chk("abort_data",    o_reg_data, 32'hCAFE_0001);

      // back-to-back with chip select held, from a clean reset
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      a0 = ack_cnt;
      i_cs = 1'b1; i_r_neg_w = 1'b1; i_addr = 6'h00;
      tick();
      i_reg_ack = 1'b1; i_reg_r_data = 32'h10;
      tick();
      chk("b2b_rd_data", o_reg_data, 32'h10);
      chk("b2b_rd_ack",  32'(o_ack), 32'h1);
      i_reg_ack = 1'b0;
      i_r_neg_w = 1'b0; i_addr = 6'h20; i_bus_data = 32'h3;
      tick();
      tick();
      chk("b2b_wr_rs", 32'(o_rs_vector), 32'h0001_0000);
      for (int i = 0; i < 6; i++) tick();
      chk("b2b_ack_cnt", 32'(ack_cnt - a0), 32'h2);
      chk("b2b_data",    o_reg_data, 32'h10);
      chk("b2b_w_bus",   o_reg_w_bus, 32'h3);
      chk("b2b_rs_idle", 32'(o_rs_vector), 32'h0);
      chk("b2b_state",   32'(dut.state_q), 32'(IDLE));
      i_cs = 1'b0;
      tick();

      // reset while a read is pending
      i_cs = 1'b1; i_r_neg_w = 1'b1; i_addr = 6'h02;
      tick();
      chk("mid_rs", 32'(o_rs_vector), 32'h2);
      i_reset = 1'b1; i_cs = 1'b0;
      tick();
      chk("mid_rst_rs",    32'(o_rs_vector), 32'h0);
      chk("mid_rst_rnw",   32'(o_r_neg_w), 32'h0);
      chk("mid_rst_data",  o_reg_data, 32'h0);
      chk("mid_rst_w_bus", o_reg_w_bus, 32'h0);
      chk("mid_rst_ack",   32'(o_ack), 32'h0);
      chk("mid_rst_err",   32'(o_error), 32'h0);
      chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      i_reset = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
